gate_bist_ctrl: RTL and testbench
=================================

# gate_bist_ctrl

Built-in self-test sequencer for the `gate_dataflow` block. On a `start` pulse it drives all four (`a`, `b`) input combinations into `gate_dataflow` and waits a programmable settle time per vector. It compares the eight gate outputs against the expected truth table and reports pass/fail, per-gate failure bits, the first failing vector and the failing-vector count. It sits between the system control logic and `gate_dataflow`, which it owns exclusively while `busy` is high.

## Interface
Parameters:
- `SETTLE`, default 1: extra cycles each vector is held before its compare.
  - Legal range 0..15.
  - Each vector occupies SETTLE+1 cycles.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to run the test; sampled only in IDLE.
- `an_d`, `o_r`, `no_t`, `no_t_b`, `na_nd`, `no_r`, `ex_or`, `ex_nor`  in  1 each  outputs of `gate_dataflow`.
- `a`, `b`  out  1 each  stimulus to `gate_dataflow`.
- `busy`  out  1  test in progress.
- `done`  out  1  one-cycle pulse when the test completes.
- `pass`  out  1  1 when the last completed test had no mismatch; held until the next start.
- `fail_mask`  out  8  sticky per-gate mismatch bits.
  - Bit order: [0]an_d [1]o_r [2]no_t [3]no_t_b [4]na_nd [5]no_r [6]ex_or [7]ex_nor.
- `first_fail`  out  2  vector index ({a,b}) of the first mismatching vector; 0 if none.
- `err_cnt`  out  3  number of vectors (0..4) with at least one mismatch.

## Operation
- States: IDLE, RUN.
  - IDLE: `start`=1 moves to RUN.
  - RUN: returns to IDLE after vector 3 is compared.
- Internal 2-bit vector index `vec` and settle counter `cnt` of width 4.
- Stimulus mapping: `a`=`vec[1]`, `b`=`vec[0]`. Vectors run in order 00, 01, 10, 11.
- Expected values per vector:
  - an_d=a&b, o_r=a|b, no_t=~a, no_t_b=~b
  - na_nd=~(a&b), no_r=~(a|b), ex_or=a^b, ex_nor=~(a^b).
- Compare edge is the edge where `cnt`==SETTLE in RUN. On that edge:
  - mismatch = actual ^ expected (8 bits); `fail_mask` |= mismatch.
  - If mismatch is nonzero: `err_cnt` increments. If it is the first failing vector of this run, `first_fail` is loaded with `vec`.
  - If `vec`<3: `vec` increments and `cnt` clears. Otherwise go to IDLE.
- Other RUN edges: `cnt` increments.
- `pass` = (`fail_mask`==0) is updated only on the final compare edge.
- `start` in RUN is ignored. There is no abort input.
- `start` is accepted in the cycle `done` is high, since the block is already in IDLE.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `first_fail`=0, `err_cnt`=0; state IDLE, `vec`=0, `cnt`=0.
- `rst` has priority over `start`.
- `rst` in RUN returns to IDLE on that edge with all outputs at reset values. No `done` pulse is produced.
- Start edge E0 (IDLE, `start`=1). After E0:
  - `busy`=1, `vec`=0, `cnt`=0, `a`=`b`=0.
  - `fail_mask`, `first_fail`, `err_cnt` and `pass` clear.
- Vector k is driven from edge E(k·(SETTLE+1)) and compared at edge E((k+1)·(SETTLE+1)).
- Gate outputs are sampled at the compare edge, so the combinational path settles within the SETTLE+1 cycles.
- Final compare edge E(4·(SETTLE+1)). After it:
  - `busy`=0, `done`=1 for exactly one cycle, `a`=`b`=0.
  - Results are valid and held.
- Total latency from the start edge to `done` high is 4·(SETTLE+1) cycles. SETTLE=1 gives 8; SETTLE=0 gives 4.
- `a`/`b` change only on compare edges and the start edge, and are never glitched mid-vector.

## Test plan
- Fault-free `gate_dataflow`, SETTLE=1, `start` at E0 -> `a`,`b` step 00,01,10,11 every 2 cycles; `done` high after E8; `pass`=1, `fail_mask`=8'h00, `err_cnt`=0, `first_fail`=0.
- `ex_or` forced to 0 -> `fail_mask`=8'h40, `err_cnt`=2, `first_fail`=2'b01, `pass`=0.
- `no_t` forced to 1, SETTLE=0 -> `done` after E4; `fail_mask`=8'h04, `err_cnt`=2, `first_fail`=2'b10.
- `start` pulsed again at E3 of a run -> ignored; `done` still after E8, with single-run results.
- `rst` asserted at E5 of a run -> next cycle all outputs at reset values; no `done`. A fresh `start` then completes normally.
- Second `start` in the `done` cycle after a failing run -> results clear on that edge; with a fault-free DUT, the next `done` shows `pass`=1, `fail_mask`=0.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_ctrl
// Purpose  : Built-in self-test sequencer for gate_dataflow. Walks the four
//            {a,b} vectors, holds each for SETTLE+1 cycles, compares the eight
//            gate outputs against their truth table and reports the results.
// Revision : 1.0 - initial release
// ============================================================================
module gate_bist_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       an_d,
    input  logic       o_r,
    input  logic       no_t,
    input  logic       no_t_b,
    input  logic       na_nd,
    input  logic       no_r,
    input  logic       ex_or,
    input  logic       ex_nor,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [1:0] first_fail,
    output logic [2:0] err_cnt
);

    // Settle count at which the current vector is compared.
    localparam logic [3:0] c_settle = 4'(SETTLE);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] vec, vec_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       done_nxt;
    logic       pass_nxt;
    logic [7:0] fail_mask_nxt;
    logic [1:0] first_fail_nxt;
    logic [2:0] err_cnt_nxt;

    logic [7:0] actual;
    logic [7:0] expected;
    logic [7:0] mismatch;

    // Stimulus comes straight from the vector register, so a/b only move on
    // the edges where vec is written (start, compare, reset).
    assign a    = vec[1];
    assign b    = vec[0];
    assign busy = (state == RUN);

    // Gate outputs packed in fail_mask bit order.
    assign actual   = {ex_nor, ex_or, no_r, na_nd, no_t_b, no_t, o_r, an_d};
    assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
    assign mismatch = actual ^ expected;

    // State and result registers; reset returns everything to idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= 2'd0;
            cnt        <= 4'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= 8'd0;
            first_fail <= 2'd0;
            err_cnt    <= 3'd0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            cnt        <= cnt_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            fail_mask  <= fail_mask_nxt;
            first_fail <= first_fail_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

    // Next-state and result update: start clears results, each compare edge
    // folds one vector's mismatch into the sticky results.
    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        cnt_nxt        = cnt;
        done_nxt       = 1'b0;
        pass_nxt       = pass;
        fail_mask_nxt  = fail_mask;
        first_fail_nxt = first_fail;
        err_cnt_nxt    = err_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt      = RUN;
                    vec_nxt        = 2'd0;
                    cnt_nxt        = 4'd0;
                    pass_nxt       = 1'b0;
                    fail_mask_nxt  = 8'd0;
                    first_fail_nxt = 2'd0;
                    err_cnt_nxt    = 3'd0;
                end
            end
            RUN: begin
                if (cnt == c_settle) begin
                    fail_mask_nxt = fail_mask | mismatch;
                    if (mismatch != 8'd0) begin
                        err_cnt_nxt = err_cnt + 3'd1;
                        // err_cnt is still zero only for the first failing vector.
                        if (err_cnt == 3'd0) begin
                            first_fail_nxt = vec;
                        end
                    end
                    cnt_nxt = 4'd0;
                    if (vec != 2'd3) begin
                        vec_nxt = vec + 2'd1;
                    end else begin
                        state_nxt = IDLE;
                        vec_nxt   = 2'd0;
                        done_nxt  = 1'b1;
                        pass_nxt  = ((fail_mask | mismatch) == 8'd0);
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                vec_nxt   = 2'd0;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_bist_ctrl
// Purpose  : Self-checking bench for gate_bist_ctrl. Two instances (SETTLE=1
//            and SETTLE=0) drive a gate_dataflow stand-in with injectable
//            stuck-at faults; a per-cycle model and literal pins check them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic chk_en = 1'b0;

    // Fault injection: bits set in fm are forced to the matching fv bit.
    logic [7:0] fm = 8'd0;
    logic [7:0] fv = 8'd0;

    int total = 0;
    int bad = 0;

    // Index 0: SETTLE=1 instance, index 1: SETTLE=0 instance.
    logic [1:0] a_o, b_o, busy_o, done_o, pass_o;
    logic [7:0] mask_o [2];
    logic [1:0] first_o [2];
    logic [2:0] err_o [2];
    logic [7:0] g [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] gate_exp(input logic ai, input logic bi);
        return {~(ai ^ bi), ai ^ bi, ~(ai | bi), ~(ai & bi), ~bi, ~ai, ai | bi, ai & bi};
    endfunction

    function automatic logic [7:0] gate_act(input logic ai, input logic bi,
                                            input logic [7:0] m, input logic [7:0] v);
        return (gate_exp(ai, bi) & ~m) | (v & m);
    endfunction

    assign g[0] = gate_act(a_o[0], b_o[0], fm, fv);
    assign g[1] = gate_act(a_o[1], b_o[1], fm, fv);

    gate_bist_ctrl #(.SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .start(start),
        .an_d(g[0][0]), .o_r(g[0][1]), .no_t(g[0][2]), .no_t_b(g[0][3]),
        .na_nd(g[0][4]), .no_r(g[0][5]), .ex_or(g[0][6]), .ex_nor(g[0][7]),
        .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .fail_mask(mask_o[0]), .first_fail(first_o[0]),
        .err_cnt(err_o[0])
    );

    gate_bist_ctrl #(.SETTLE(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .start(start),
        .an_d(g[1][0]), .o_r(g[1][1]), .no_t(g[1][2]), .no_t_b(g[1][3]),
        .na_nd(g[1][4]), .no_r(g[1][5]), .ex_or(g[1][6]), .ex_nor(g[1][7]),
        .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .fail_mask(mask_o[1]), .first_fail(first_o[1]),
        .err_cnt(err_o[1])
    );

    // ---------------- behavioural model ----------------
    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Whole-test outcome for a given fault: {pass, mask, first_fail, err_cnt}.
    function automatic logic [13:0] run_result(input logic [7:0] m, input logic [7:0] v);
        logic [7:0] mask;
        logic [7:0] mm;
        logic [1:0] first;
        int         errs;
        mask = 8'd0; first = 2'd0; errs = 0;
        for (int k = 0; k < 4; k++) begin
            mm = gate_act(k[1], k[0], m, v) ^ gate_exp(k[1], k[0]);
            mask |= mm;
            if (mm != 8'd0) begin
                if (errs == 0) first = k[1:0];
                errs++;
            end
        end
        return {(mask == 8'd0), mask, first, 3'(errs)};
    endfunction

    logic       m_run  [2] = '{1'b0, 1'b0};
    logic       m_done [2] = '{1'b0, 1'b0};
    int         m_t    [2] = '{0, 0};
    logic [13:0] m_res [2] = '{14'd0, 14'd0};

    // Model: m_t counts edges since the start edge; final results are known
    // up front and only checked once the run is over.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i]  <= 1'b0;
                m_done[i] <= 1'b0;
                m_t[i]    <= 0;
                m_res[i]  <= 14'd0;
            end else begin
                m_done[i] <= 1'b0;
                if (!m_run[i]) begin
                    if (start) begin
                        m_run[i] <= 1'b1;
                        m_t[i]   <= 0;
                        m_res[i] <= run_result(fm, fv);
                    end
                end else if (m_t[i] + 1 == 4 * (settle_of(i) + 1)) begin
                    m_run[i]  <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_t[i]    <= 0;
                end else begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int k;
                k = m_run[i] ? (m_t[i] / (settle_of(i) + 1)) : 0;
                chk("busy", i, 32'(busy_o[i]), 32'(m_run[i]));
                chk("done", i, 32'(done_o[i]), 32'(m_done[i]));
                chk("a", i, 32'(a_o[i]), 32'((k >> 1) & 1));
                chk("b", i, 32'(b_o[i]), 32'(k & 1));
                if (!m_run[i]) begin
                    chk("pass", i, 32'(pass_o[i]), 32'(m_res[i][13]));
                    chk("fail_mask", i, 32'(mask_o[i]), 32'(m_res[i][12:5]));
                    chk("first_fail", i, 32'(first_o[i]), 32'(m_res[i][4:3]));
                    chk("err_cnt", i, 32'(err_o[i]), 32'(m_res[i][2:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges counted from the last launch/pulse edge until each instance's done.
    task automatic wait_done(output int lat1, output int lat0);
        lat1 = -1;
        lat0 = -1;
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk);
            #1;
            if (done_o[0] && lat1 < 0) lat1 = j;
            if (done_o[1] && lat0 < 0) lat0 = j;
            if (lat1 >= 0 && lat0 >= 0) break;
        end
    endtask

    int l1, l0;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("reset_mask", 0, 32'(mask_o[0]), 32'd0);
        chk("reset_pass", 1, 32'(pass_o[1]), 32'd0);

        // Fault-free run.
        launch();
        wait_done(l1, l0);
        chk("lat_s1", 0, 32'(l1), 32'd8);
        chk("lat_s0", 1, 32'(l0), 32'd4);
        chk("ff_pass", 0, 32'(pass_o[0]), 32'd1);
        chk("ff_mask", 0, 32'(mask_o[0]), 32'h00);
        chk("ff_err", 0, 32'(err_o[0]), 32'd0);
        chk("ff_first", 0, 32'(first_o[0]), 32'd0);

        // ex_or stuck at 0.
        fm = 8'h40; fv = 8'h00;
        launch();
        wait_done(l1, l0);
        chk("exor_mask", 0, 32'(mask_o[0]), 32'h40);
        chk("exor_err", 0, 32'(err_o[0]), 32'd2);
        chk("exor_first", 0, 32'(first_o[0]), 32'd1);
        chk("exor_pass", 0, 32'(pass_o[0]), 32'd0);

        // no_t stuck at 1, checked on the SETTLE=0 instance.
        fm = 8'h04; fv = 8'h04;
        launch();
        wait_done(l1, l0);
        chk("not_lat", 1, 32'(l0), 32'd4);
        chk("not_mask", 1, 32'(mask_o[1]), 32'h04);
        chk("not_err", 1, 32'(err_o[1]), 32'd2);
        chk("not_first", 1, 32'(first_o[1]), 32'd2);

        // Second start pulse at E3 is ignored.
        fm = 8'h00; fv = 8'h00;
        launch();
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(l1, l0);
        chk("restart_lat", 0, 32'(l1), 32'd5);
        chk("restart_pass", 0, 32'(pass_o[0]), 32'd1);

        // Reset at E5 of a failing run: no done, everything back to reset.
        fm = 8'h40; fv = 8'h00;
        launch();
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rst_mask", 0, 32'(mask_o[0]), 32'd0);
        chk("rst_err", 0, 32'(err_o[0]), 32'd0);
        chk("rst_mask_s0", 1, 32'(mask_o[1]), 32'd0);
        repeat (10) @(posedge clk);
        fm = 8'h00;
        launch();
        wait_done(l1, l0);
        chk("post_rst_lat", 0, 32'(l1), 32'd8);
        chk("post_rst_pass", 0, 32'(pass_o[0]), 32'd1);

        // Start in the done cycle of a failing run clears results at once.
        fm = 8'h40; fv = 8'h00;
        launch();
        wait_done(l1, l0);
        chk("b2b_fail_mask", 0, 32'(mask_o[0]), 32'h40);
        fm = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_clear_mask", 0, 32'(mask_o[0]), 32'h00);
        chk("b2b_clear_err", 0, 32'(err_o[0]), 32'd0);
        chk("b2b_busy", 0, 32'(busy_o[0]), 32'd1);
        wait_done(l1, l0);
        chk("b2b_lat", 0, 32'(l1), 32'd8);
        chk("b2b_pass", 0, 32'(pass_o[0]), 32'd1);
        chk("b2b_mask", 0, 32'(mask_o[0]), 32'h00);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
